// File: rtl/editor_campos_datos.sv
// Nine-field value editor with inc/dec/next/prev controls and a ready/valid field stream.
// Optional macro DATOS_BCD_OUT_EN: streams each field as two BCD digits instead of binary.
module editor_campos_datos (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  input  logic       next,
  input  logic       prev,
  input  logic       commit,
  output logic [3:0] c_1,
  output logic [6:0] valor,
  output logic [7:0] dout,
  output logic [3:0] dout_idx,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy
);

  localparam int DATA_W  = 7;
  localparam int NCAMPOS = 9;
  localparam logic [3:0] ULTIMO = 4'd8;

  typedef enum logic [1:0] {IDLE, EDIT, SEND} estado_t;

  estado_t           estado, estado_sig;
  logic [DATA_W-1:0] campo [NCAMPOS];
  logic [DATA_W-1:0] sel_val, campo_nuevo, sel_lim;
  logic [3:0]        c_1_sig;

  function automatic logic [DATA_W-1:0] limite(input logic [3:0] i);
    case (i)
      4'd0:       limite = 7'd23;
      4'd1, 4'd2: limite = 7'd59;
      4'd3:       limite = 7'd30;
      4'd4:       limite = 7'd11;
      4'd5:       limite = 7'd99;
      4'd6:       limite = 7'd23;
      default:    limite = 7'd59;
    endcase
  endfunction

  function automatic logic [7:0] formato(input logic [DATA_W-1:0] v);
`ifdef DATOS_BCD_OUT_EN
    logic [3:0] decenas, unidades;
    decenas  = 4'(v / 7'd10);
    unidades = 4'(v % 7'd10);
    formato  = {decenas, unidades};
`else
    formato = {1'b0, v};
`endif
  endfunction

  assign sel_val = campo[c_1];
  assign sel_lim = limite(c_1);
  assign valor   = sel_val;
  assign busy    = (estado == SEND);

  // Edits target the field selected before this cycle's next/prev takes effect
  always_comb begin
    campo_nuevo = sel_val;
    if (inc && !dec)
      campo_nuevo = (sel_val >= sel_lim) ? '0 : sel_val + 7'd1;
    else if (dec && !inc)
      campo_nuevo = (sel_val == '0) ? sel_lim : sel_val - 7'd1;
  end

  always_comb begin
    c_1_sig = c_1;
    if (next && !prev)
      c_1_sig = (c_1 == ULTIMO) ? 4'd0 : c_1 + 4'd1;
    else if (prev && !next)
      c_1_sig = (c_1 == 4'd0) ? ULTIMO : c_1 - 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      estado <= IDLE;
    else
      estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE: if (en) estado_sig = EDIT;
      EDIT: begin
        if (!en)
          estado_sig = IDLE;
        else if (commit)
          estado_sig = SEND;
      end
      SEND: begin
        if (dout_valid && dout_ready && dout_idx == ULTIMO)
          estado_sig = en ? EDIT : IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCAMPOS; i++)
        campo[i] <= '0;
      c_1 <= 4'd0;
    end else if (estado == EDIT) begin
      campo[c_1] <= campo_nuevo;
      c_1        <= c_1_sig;
    end
  end

  // Fields are frozen during SEND, so each word is formatted as it is loaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= 8'd0;
      dout_idx   <= 4'd0;
      dout_valid <= 1'b0;
    end else if (estado == SEND) begin
      if (!dout_valid) begin
        dout_valid <= 1'b1;
        dout_idx   <= 4'd0;
        dout       <= formato(campo[0]);
      end else if (dout_ready) begin
        if (dout_idx == ULTIMO) begin
          dout_valid <= 1'b0;
        end else begin
          dout_idx <= dout_idx + 4'd1;
          dout     <= formato(campo[dout_idx + 4'd1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_editor_campos_datos.sv
// Directed and randomized bench for editor_campos_datos against a field/stream reference model.
module tb_editor_campos_datos;

  logic       clk = 1'b0;
  logic       reset, en, inc, dec, next, prev, commit, dout_ready;
  logic [3:0] c_1, dout_idx;
  logic [6:0] valor;
  logic [7:0] dout;
  logic       dout_valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  editor_campos_datos dut (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .next(next),
    .prev(prev), .commit(commit), .c_1(c_1), .valor(valor), .dout(dout),
    .dout_idx(dout_idx), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 editing, 2 streaming
  int lims [9] = '{23, 59, 59, 30, 11, 99, 23, 59, 59};
  int mf   [9];
  int snap [9];
  int m_mode, m_sel, m_idx;
  bit m_valid;

  function automatic int fmt(input int v);
`ifdef DATOS_BCD_OUT_EN
    return (v / 10) * 16 + (v % 10);
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mf[i] = 0;
    m_mode = 0; m_sel = 0; m_idx = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    int s;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        s = m_sel;
        if (inc && !dec) mf[s] = (mf[s] + 1) % (lims[s] + 1);
        else if (dec && !inc) mf[s] = (mf[s] == 0) ? lims[s] : mf[s] - 1;
        if (next && !prev) m_sel = (m_sel + 1) % 9;
        else if (prev && !next) m_sel = (m_sel + 8) % 9;
        if (!en) m_mode = 0;
        else if (commit) begin
          m_mode = 2;
          for (int i = 0; i < 9; i++) snap[i] = mf[i];
        end
      end
      default: begin
        if (!m_valid) begin
          m_valid = 1; m_idx = 0;
        end else if (dout_ready) begin
          if (m_idx == 8) begin
            m_valid = 0;
            m_mode = en ? 1 : 0;
          end else m_idx++;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("c_1", 32'(c_1), 32'(m_sel));
    chk("valor", 32'(valor), 32'(mf[m_sel]));
    chk("busy", 32'(busy), 32'(m_mode == 2));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    if (m_valid) begin
      chk("dout_idx", 32'(dout_idx), 32'(m_idx));
      chk("dout", 32'(dout), 32'(fmt(snap[m_idx])));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    inc = 0; dec = 0; next = 0; prev = 0; commit = 0;
    check_all();
  endtask

  initial begin
    reset = 0; en = 0; inc = 0; dec = 0; next = 0; prev = 0; commit = 0; dout_ready = 1;
    #2;
    chk("rst_c_1", 32'(c_1), 0);
    chk("rst_valor", 32'(valor), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_idx", 32'(dout_idx), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    model_reset();
    reset = 1;
    tick();

    // inc wraps field 0 at 23
    en = 1;
    tick();
    for (int k = 0; k < 24; k++) begin
      inc = 1; tick();
      chk("inc_wrap_f0", 32'(valor), 32'((k + 1) % 24));
    end

    // dec on field 5 at 0 wraps to 99
    for (int k = 0; k < 5; k++) begin next = 1; tick(); end
    dec = 1; tick();
    chk("sel5", 32'(c_1), 5);
    chk("dec_wrap_f5", 32'(valor), 99);

    // prev wrap, then inc+next together at field 8
    for (int k = 0; k < 4; k++) begin next = 1; tick(); end
    chk("next_wrap", 32'(c_1), 0);
    prev = 1; tick();
    chk("prev_wrap", 32'(c_1), 8);
    dec = 1; tick();
    chk("f8_lim", 32'(valor), 59);
    inc = 1; next = 1; tick();
    chk("inc_next_sel", 32'(c_1), 0);
    prev = 1; tick();
    chk("inc_next_f8", 32'(valor), 0);

    // field 1 = 45, full stream with ready held high
    next = 1; tick();
    next = 1; tick();
    for (int k = 0; k < 45; k++) begin inc = 1; tick(); end
    chk("f1_45", 32'(valor), 45);
    commit = 1; tick();
    chk("send_busy", 32'(busy), 1);
    chk("send_first_invalid", 32'(dout_valid), 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("stream_idx", 32'(dout_idx), 32'(k));
      chk("stream_valid", 32'(dout_valid), 1);
`ifdef DATOS_BCD_OUT_EN
      if (k == 1) chk("dout_f1_bcd", 32'(dout), 32'h45);
`else
      if (k == 1) chk("dout_f1_bin", 32'(dout), 32'h2D);
`endif
    end
    tick();
    chk("end_valid", 32'(dout_valid), 0);
    chk("end_busy", 32'(busy), 0);

    // backpressure at index 4
    commit = 1; tick();
    for (int k = 0; k < 20 && !(m_valid && m_idx == 4); k++) tick();
    chk("reach_idx4", 32'(dout_idx), 4);
    dout_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_idx", 32'(dout_idx), 4);
      chk("hold_dout", 32'(dout), 32'(fmt(mf[4])));
    end
    dout_ready = 1;
    for (int k = 0; k < 20 && m_mode == 2; k++) tick();
    chk("bp_done", 32'(busy), 0);

    // reset mid-stream aborts immediately
    commit = 1; tick();
    for (int k = 0; k < 20 && !(m_valid && m_idx == 3); k++) tick();
    chk("reach_idx3", 32'(dout_idx), 3);
    #2;
    reset = 0;
    #1;
    chk("abort_valid", 32'(dout_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_c_1", 32'(c_1), 0);
    chk("abort_valor", 32'(valor), 0);
    model_reset();
    reset = 1;

    // randomized traffic including en drops mid-stream
    for (int k = 0; k < 1500; k++) begin
      en         = ($urandom_range(0, 15) != 0);
      inc        = ($urandom_range(0, 3) == 0);
      dec        = ($urandom_range(0, 3) == 0);
      next       = ($urandom_range(0, 3) == 0);
      prev       = ($urandom_range(0, 3) == 0);
      commit     = ($urandom_range(0, 23) == 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/editor_campos_datos.md
EDITOR_CAMPOS_DATOS -- requirements
Module: editor_campos_datos

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  edit enable; 1 allows field editing.
- inc  input  1  single-cycle pulse; increment the selected field.
- dec  input  1  single-cycle pulse; decrement the selected field.
- next  input  1  single-cycle pulse; select the next field.
- prev  input  1  single-cycle pulse; select the previous field.
- commit  input  1  single-cycle pulse; start streaming all fields out.
- c_1  output  4  index of the selected field, 0..8.
- valor  output  7  current value of the selected field.
- dout  output  8  streamed field data.
- dout_idx  output  4  index of the field on dout.
- dout_valid  output  1  dout and dout_idx are valid.
- dout_ready  input  1  consumer accepts dout when high with dout_valid.
- busy  output  1  high while streaming.

Function
REQ-002 The block SHALL hold nine 7-bit field registers with fixed upper limits:
- 0: 23
- 1: 59
- 2: 59
- 3: 30
- 4: 11
- 5: 99
- 6: 23
- 7: 59
- 8: 59

REQ-003 The FSM SHALL have three states: IDLE, EDIT, SEND.
- IDLE -> EDIT when en=1.
- EDIT -> IDLE when en=0.
- EDIT -> SEND on commit.

REQ-004 In IDLE and SEND, inc, dec, next, prev and commit SHALL be ignored.

REQ-005 In EDIT, inc SHALL add 1 to the selected field, and inc at the limit SHALL wrap the field to 0.

REQ-006 In EDIT, dec SHALL subtract 1 from the selected field, and dec at 0 SHALL wrap the field to its limit.

REQ-007 Simultaneous inc and dec SHALL leave the field unchanged.

REQ-008 In EDIT, next SHALL advance c_1 with wrap 8->0, and prev SHALL retreat c_1 with wrap 0->8.

REQ-009 Simultaneous next and prev SHALL leave c_1 unchanged.

REQ-010 When inc/dec and next/prev arrive in the same cycle, the value change SHALL apply to the field indexed by the pre-update c_1.

REQ-011 When commit coincides with inc, dec, next or prev, the edits SHALL apply first and SEND SHALL stream the updated values.

REQ-012 valor SHALL be combinational from the field register indexed by c_1 (0 latency).

REQ-013 On entry to SEND:
- dout_valid SHALL assert in the next cycle with dout_idx=0.
- busy SHALL be 1 for the whole of SEND.

REQ-014 dout, dout_idx and dout_valid SHALL be registered and held stable while dout_valid=1 and dout_ready=0.

REQ-015 A transfer SHALL occur on any cycle with dout_valid=1 and dout_ready=1; dout_idx SHALL then advance by 1 in the next cycle with dout_valid kept at 1 (one field per cycle when ready stays high).

REQ-016 After the transfer of index 8:
- dout_valid SHALL drop in the next cycle.
- The FSM SHALL go to EDIT if en=1, else IDLE.

REQ-017 Deasserting en during SEND SHALL NOT abort the stream.

REQ-018 Field registers SHALL never hold a value above their limit.

Reset
REQ-019 While reset=0, the block SHALL asynchronously force:
- state IDLE;
- all fields 0;
- c_1=0;
- dout=0, dout_idx=0;
- dout_valid=0, busy=0.

REQ-020 Reset asserted during SEND SHALL abort the stream immediately, with no further transfers.

REQ-021 After reset deasserts, the block SHALL act on the first rising clk edge.

Configuration
REQ-022 The macro DATOS_BCD_OUT_EN SHALL select the dout format:
- Defined: dout = {tens[3:0], units[3:0]} BCD of the field value, e.g. 59 -> 8'h59.
- Undefined: dout = {1'b0, field} binary, e.g. 59 -> 8'h3B.

REQ-023 DATOS_BCD_OUT_EN SHALL NOT affect valor, timing or handshake.

Verification
REQ-024 Reset, en=1, 24 inc pulses on field 0 -> valor sequence 1..23 then 0.

REQ-025 next x5, dec once on field 5 -> c_1=5, valor=99.

REQ-026 prev at c_1=0 -> c_1=8; inc+next in the same cycle at c_1=8 with field 8 = 59 -> field 8 = 0, c_1=0.

REQ-027 commit with dout_ready=1 -> dout_idx 0..8 on consecutive cycles, then dout_valid=0 and busy=0. Holding dout_ready=0 for 3 cycles at idx 4 -> dout held unchanged.

REQ-028 Field 1 = 45, commit:
- DATOS_BCD_OUT_EN defined -> dout=8'h45 at idx 1.
- Undefined -> dout=8'h2D.

REQ-029 reset low at idx 3 in SEND -> dout_valid=0 and all fields 0 before the next clk edge.
